multiword_add_sequencer: RTL and testbench
==========================================

// Module: multiword_add_sequencer
// PURPOSE
//  Serial multi-precision adder built around the team's 16-bit carry-select adder (Adder16Bit).
//  Accepts two WORDS*16-bit operands over a valid/ready handshake.
//  Feeds one 16-bit slice per cycle, LSW first, into a single Adder16Bit instance.
//  Chains the carry through a flop and returns the full-width sum plus carry-out over a second valid/ready handshake.
//  Sits directly upstream of the adder: it owns the adder's x/y/Cin inputs and consumes its Sum/Cout.
// PARAMETERS
//  WORDS   4   number of 16-bit slices per operand (min 1); operand width W = 16*WORDS
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   block can accept operands
//  a          in   W   operand A
//  b          in   W   operand B
//  cin        in   1   carry-in to LSW slice
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  sum        out  W   result, registered
//  cout       out  1   carry-out of MSW slice, registered
//  busy       out  1   high in RUN or DONE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, slice index=0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready, capture a, b, cin into registers; idx=0; go to RUN.
//   RUN: in_ready=0. Drive adder x=a_r[16*idx+:16], y=b_r[16*idx+:16], Cin=carry_r.
//        Each edge: sum[16*idx+:16]<=adder Sum; carry_r<=adder Cout; idx++.
//        When idx==WORDS-1: cout<=adder Cout, out_valid<=1, go to DONE.
//   DONE: sum/cout stable. On out_valid&out_ready: out_valid<=0, go to IDLE.
//  Latency: operands accepted on edge t; out_valid is high after edge t+WORDS.
//  Throughput: at most one operation per WORDS+2 cycles.
//  in_ready is never high in RUN or DONE. in_valid there is ignored; no operand overwrite.
//  Adder inputs are combinational from the registers. No extra pipeline stage inside the slice loop.
//  sum may show partial slices during RUN. Its value is only defined while out_valid=1.
//  Full-width wrap: the result is modulo 2^W; overflow is reported only via cout.
//  Reset mid-RUN or mid-DONE aborts the operation: all outputs return to reset values and no result is emitted.
//  WORDS=1: RUN lasts exactly one cycle.
// CONFIGURATION
//  Macro MWADD_SUB_EN:
//   Defined: adds input op_sub (1 bit), captured with the operands.
//    op_sub=1: y=~b slice, initial carry_r=~cin (cin acts as borrow-in).
//    op_sub=1: cout reports borrow = ~(final carry); sum = a-b-cin mod 2^W.
//    op_sub=0: identical to the add path.
//   Undefined: op_sub port absent; add only; no inversion logic synthesised.
// STRUCTURE
//  Package mwadd_pkg:
//   localparam WORD_W=16.
//   typedef enum logic[1:0] {IDLE, RUN, DONE} mwadd_state_t.
//   Slice index type sized $clog2(WORDS) (min 1 bit), declared in-module.
//  Exactly one sub-module: a single Adder16Bit instance. No other hierarchy.
// TESTING (WORDS=4 unless stated)
//  1 a=0x0000_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x0001_0000_0000_0000, cout=0; out_valid exactly 4 cycles after accept.
//  2 a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=1.
//  3 Hold out_ready=0 for 10 cycles in DONE; present new in_valid -> sum/cout stable, in_ready=0, new op not captured.
//  4 Assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately; the next op (a=3,b=4) gives sum=7.
//  5 Two back-to-back ops with in_valid held high and out_ready=1 -> second accepted only after the first result handshake; results in order.
//  6 MWADD_SUB_EN defined: a=0, b=1, op_sub=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=1 (borrow); a=5, b=3 -> sum=2, cout=0.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package mwadd_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwadd_state_t;

    // Slice index width: ceil(log2(words)), never narrower than one bit.
    function automatic int idx_width(input int words);
        idx_width = (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// Adder16Bit: 16-bit carry-select adder (8-bit ripple low half, upper half
// precomputed for both carry values and selected by the low-half carry).
module Adder16Bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [8:0] lo_s;
    logic [8:0] hi0_s;
    logic [8:0] hi1_s;

    // Low half ripple plus both speculative upper halves, then select.
    always_comb begin
        lo_s  = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'd0, Cin};
        hi0_s = {1'b0, x[15:8]} + {1'b0, y[15:8]};
        hi1_s = {1'b0, x[15:8]} + {1'b0, y[15:8]} + 9'd1;
        if (lo_s[8]) begin
            Sum  = {hi1_s[7:0], lo_s[7:0]};
            Cout = hi1_s[8];
        end else begin
            Sum  = {hi0_s[7:0], lo_s[7:0]};
            Cout = hi0_s[8];
        end
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Serial multi-precision adder: one 16-bit slice per cycle through Adder16Bit.
// Optional subtract path enabled by defining MWADD_SUB_EN.
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
`ifdef MWADD_SUB_EN
    input  logic                  op_sub,
`endif
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);

    typedef logic [IDX_W-1:0] idx_t;

    mwadd_state_t      state_r;
    mwadd_state_t      state_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              carry_r;
    idx_t              idx_r;
    logic [W-1:0]      sum_r;
    logic              cout_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              op_sub_r;

    logic              accept_s;
    logic              last_s;
    logic              handshake_s;
    logic              cin_init_s;
    logic [WORD_W-1:0] x_s;
    logic [WORD_W-1:0] y_s;
    logic [WORD_W-1:0] add_sum_s;
    logic              add_cout_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign busy      = busy_r;

    // Handshake qualifiers and the current slice position.
    always_comb begin
        accept_s    = (state_r == IDLE) && in_valid && in_ready_r;
        last_s      = (idx_r == idx_t'(WORDS - 1));
        handshake_s = out_valid_r && out_ready;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (handshake_s) state_s = IDLE;
                else             state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

`ifdef MWADD_SUB_EN
    // Subtract runs as a + ~b + ~cin, so cin behaves as a borrow-in.
    always_comb begin
        x_s        = a_r[WORD_W*idx_r +: WORD_W];
        y_s        = b_r[WORD_W*idx_r +: WORD_W] ^ {WORD_W{op_sub_r}};
        cin_init_s = cin ^ op_sub;
    end
`else
    // Adder operands come straight from the captured registers.
    always_comb begin
        x_s        = a_r[WORD_W*idx_r +: WORD_W];
        y_s        = b_r[WORD_W*idx_r +: WORD_W];
        cin_init_s = cin;
    end
`endif

    Adder16Bit u_adder (
        .x    (x_s),
        .y    (y_s),
        .Cin  (carry_r),
        .Sum  (add_sum_s),
        .Cout (add_cout_s)
    );

    // Operand capture, slice accumulation and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= idx_t'(0);
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            op_sub_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin_init_s;
                        idx_r   <= idx_t'(0);
`ifdef MWADD_SUB_EN
                        op_sub_r <= op_sub;
`else
                        op_sub_r <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum_r[WORD_W*idx_r +: WORD_W] <= add_sum_s;
                    carry_r                       <= add_cout_s;
                    if (last_s) begin
                        // Final carry is inverted to a borrow when subtracting.
                        cout_r      <= add_cout_s ^ op_sub_r;
                        out_valid_r <= 1'b1;
                        idx_r       <= idx_t'(0);
                    end else begin
                        idx_r <= idx_r + idx_t'(1);
                    end
                end
                DONE: begin
                    if (handshake_s) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_s == IDLE);
            busy_r     <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=4); the subtract case
// is exercised only when MWADD_SUB_EN is defined.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef MWADD_SUB_EN
    logic         op_sub = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W:0] exp_q[$];
    int         lat_q[$];
    bit         seen_ov = 1'b0;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef MWADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, result on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_ov = 1'b0;
        end else if (out_valid) begin
            if (!seen_ov) begin
                seen_ov = 1'b1;
                if (lat_q.size() > 0) chk("latency", (W+1)'(cyc - lat_q.pop_front()), (W+1)'(WORDS));
            end
            if (out_ready) begin
                seen_ov = 1'b0;
                if (exp_q.size() > 0) begin
                    chk("result", {cout, sum}, exp_q.pop_front());
                end else begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %h expected none", {cout, sum});
                end
            end
        end
    end

    // Present one operation, wait for acceptance, push its expectation.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input logic ts, input logic [W:0] exp, input bit hold, output int acc);
        bit rdy;
        a = ta;
        b = tbv;
        cin = tc;
`ifdef MWADD_SUB_EN
        op_sub = ts;
`endif
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = cyc;
                exp_q.push_back(exp);
                lat_q.push_back(cyc);
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept (ts=%0b)", ts);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc1;
        int acc2;
        int n;

        #12;
        chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
        chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_sum_cout", {cout, sum}, 65'd0);
        chk("rst_busy", {64'd0, busy}, 65'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: carry ripples across three slices
        send(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {1'b0, 64'h0001_0000_0000_0000}, 1'b0, acc1);
        chk("t1_busy", {64'd0, busy}, 65'd1);
        chk("t1_in_ready", {64'd0, in_ready}, 65'd0);
        drain("t1");

        // 2: all ones plus all ones plus carry-in
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
             {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, acc1);
        drain("t2");

        // 3: stall in DONE with a competing request
        out_ready = 1'b0;
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0,
             {1'b1, 64'h0000_0000_0000_0002}, 1'b0, acc1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_out_valid", {64'd0, out_valid}, 65'd1);
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h1111_1111_1111_1111;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t3_hold_result", {cout, sum}, {1'b1, 64'h0000_0000_0000_0002});
            chk("t3_hold_in_ready", {64'd0, in_ready}, 65'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("t3");
        chk("t3_no_capture", {63'd0, busy, out_valid}, 65'd0);

        // 4: reset during RUN aborts the operation
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0,
             {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, acc1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        lat_q.delete();
        chk("t4_out_valid", {64'd0, out_valid}, 65'd0);
        chk("t4_sum", {1'b0, sum}, 65'd0);
        chk("t4_in_ready", {64'd0, in_ready}, 65'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'd3, 64'd4, 1'b0, 1'b0, {1'b0, 64'd7}, 1'b0, acc1);
        drain("t4");

        // 5: back-to-back with in_valid held high
        send(64'd1, 64'd2, 1'b0, 1'b0, {1'b0, 64'd3}, 1'b1, acc1);
        send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0,
             {1'b1, 64'h0000_0001_0000_0000}, 1'b0, acc2);
        chk("t5_spacing", {64'd0, (acc2 - acc1) >= (WORDS + 2)}, 65'd1);
        drain("t5");

`ifdef MWADD_SUB_EN
        // 6: subtract with borrow out, then without
        send(64'd0, 64'd1, 1'b0, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, acc1);
        drain("t6a");
        send(64'd5, 64'd3, 1'b0, 1'b1, {1'b0, 64'd2}, 1'b0, acc1);
        drain("t6b");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
